hbus_phy_target: RTL

// - HyperRAM-style responder that attaches directly to the controller-side

---
 rtl/hbus_phy_target_pkg.sv | 45 ++++
 rtl/hbus_tgt_bank.sv | 35 +++
 rtl/hbus_phy_target.sv | 203 ++++++++++++++++++++
 3 files changed

// File: rtl/hbus_phy_target_pkg.sv
// Shared definitions for the HyperBus PHY-side target model: command/address
// bit positions, register-space word addresses, state and response encodings,
// and the burst address-advance helper.
package hbus_phy_target_pkg;

  // CA[47:16] is collected in a 32-bit shifter, so CA bit n sits at n-CA_HI_LSB.
  localparam int unsigned CA_RW_BIT   = 47;
  localparam int unsigned CA_REG_BIT  = 46;
  localparam int unsigned CA_LIN_BIT  = 45;
  localparam int unsigned CA_ADDR_HI  = 44;
  localparam int unsigned CA_HI_LSB   = 16;

  localparam logic [31:0] REG_ID0_ADDR = 32'h0000_0000;
  localparam logic [31:0] REG_ID1_ADDR = 32'h0000_0001;
  localparam logic [31:0] REG_CR0_ADDR = 32'h0000_0800;
  localparam logic [31:0] REG_CR1_ADDR = 32'h0000_0801;

  localparam logic [15:0] CR1_RST = 16'h0002;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CA,
    ST_LAT,
    ST_RDATA,
    ST_WDATA,
    ST_RWR,
    ST_DONE
  } state_t;

  // What a pulse will put on its two response beats two clocks later.
  typedef enum logic [1:0] {
    RSP_NONE,
    RSP_CA,
    RSP_RAM,
    RSP_REG
  } rsp_t;

  // Linear bursts count through the full word address; wrapped bursts stay in
  // their 16-word group.
  function automatic logic [31:0] next_word_addr(input logic [31:0] a, input logic wrap);
    if (wrap) return {a[31:4], a[3:0] + 4'd1};
    return a + 32'd1;
  endfunction

endpackage

// File: rtl/hbus_tgt_bank.sv
// One bank of the target RAM: 2^(AW-1) x 16 bit, single port, per-byte write
// enables, registered read data (valid the clock after the access).
//   clk    in  clock
//   en     in  access this cycle
//   we     in  1 = write, 0 = read
//   be     in  byte enables, [1] = bits 15:8, [0] = bits 7:0
//   addr   in  word address within the bank
//   wdata  in  write data
//   rdata  out read data, registered
module hbus_tgt_bank #(
  parameter int unsigned AW = 10
) (
  input  logic          clk,
  input  logic          en,
  input  logic          we,
  input  logic [1:0]    be,
  input  logic [AW-2:0] addr,
  input  logic [15:0]   wdata,
  output logic [15:0]   rdata
);

  logic [15:0] mem [0:(1 << (AW-1))-1];

  always_ff @(posedge clk) begin
    if (en) begin
      if (we) begin
        if (be[1]) mem[addr][15:8] <= wdata[15:8];
        if (be[0]) mem[addr][7:0]  <= wdata[7:0];
      end else begin
        rdata <= mem[addr];
      end
    end
  end

endmodule

// File: rtl/hbus_phy_target.sv
// HyperRAM-style responder on the controller side of a 4-beat/2-pulse
// HyperBus PHY. Captures CA, applies doubled fixed latency, serves
// linear/wrapped bursts from even/odd RAM banks and implements CR0/CR1/ID0/ID1.
//   clk           in  PHY clk_1x
//   rst_n         in  synchronous reset, active low
//   phy_ck_en     in  [h]=1: CK pulse h valid (beats 2h, 2h+1)
//   phy_cs_n      in  chip select, active low
//   phy_dq_out    in  controller DQ, beat k = [8k+7:8k]
//   phy_dq_oe     in  controller drives DQ on pulse h
//   phy_rwds_out  in  per-beat RWDS (write mask, 1 = masked)
//   phy_rwds_oe   in  controller drives RWDS on pulse h
//   phy_dq_in     out response DQ, pulse of cycle N shows at cycle N+2
//   phy_rwds_in   out response RWDS, same timing
//   cfg_cr0       out current CR0
//   busy          out FSM not idle
module hbus_phy_target
  import hbus_phy_target_pkg::*;
#(
  parameter int unsigned AW      = 10,
  parameter int unsigned LATENCY = 6,
  parameter logic [15:0] ID0     = 16'h0c81,
  parameter logic [15:0] ID1     = 16'h0001,
  parameter logic [15:0] CR0_RST = 16'h8f1f
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [1:0]  phy_ck_en,
  input  logic        phy_cs_n,
  input  logic [31:0] phy_dq_out,
  input  logic [1:0]  phy_dq_oe,
  input  logic [3:0]  phy_rwds_out,
  input  logic [1:0]  phy_rwds_oe,
  output logic [31:0] phy_dq_in,
  output logic [3:0]  phy_rwds_in,
  output logic [15:0] cfg_cr0,
  output logic        busy
);

  localparam logic [7:0] LAT_PULSES = 8'(2 * LATENCY);

  state_t      st_q, st_d;
  logic [31:0] ca_q, ca_d;
  logic [1:0]  ccnt_q, ccnt_d;
  logic [7:0]  lcnt_q, lcnt_d;
  logic [31:0] addr_q, addr_d;
  logic        rd_q, rd_d, reg_q, reg_d, wrap_q, wrap_d;
  logic [15:0] cr0_q, cr0_d, cr1_q, cr1_d;

  logic [1:0]    bk_en, bk_we;
  logic [1:0]    bk_be    [2];
  logic [AW-2:0] bk_addr  [2];
  logic [15:0]   bk_wdata [2];
  logic [15:0]   bk_rdata [2];

  rsp_t        p_kind [2];
  logic [1:0]  p_bank;
  logic [15:0] p_val  [2];
  rsp_t        s1_kind [2];
  logic [1:0]  s1_bank;
  logic [15:0] s1_val  [2];
  logic [31:0] dq_d, dq_q;
  logic [3:0]  rwds_d, rwds_q;

  function automatic logic [15:0] reg_read(input logic [31:0] a, input logic [15:0] c0,
                                           input logic [15:0] c1);
    if (a == REG_ID0_ADDR) return ID0;
    if (a == REG_ID1_ADDR) return ID1;
    if (a == REG_CR0_ADDR) return c0;
    if (a == REG_CR1_ADDR) return c1;
    return '0;
  endfunction

  // Both pulses of a cycle are walked in order through the same next-state
  // variables, so a CA that ends on pulse 0 hands pulse 1 to LAT/RWR directly.
  always_comb begin
    st_d   = st_q;   ca_d   = ca_q;   ccnt_d = ccnt_q; lcnt_d = lcnt_q;
    addr_d = addr_q; rd_d   = rd_q;   reg_d  = reg_q;  wrap_d = wrap_q;
    cr0_d  = cr0_q;  cr1_d  = cr1_q;
    bk_en  = '0;     bk_we  = '0;     p_bank = '0;
    for (int unsigned b = 0; b < 2; b++) begin
      bk_be[b] = '0; bk_addr[b] = '0; bk_wdata[b] = '0;
      p_kind[b] = RSP_NONE; p_val[b] = '0;
    end
    if (phy_cs_n) begin
      st_d = ST_IDLE;
    end else begin
      if (st_d == ST_IDLE) begin
        st_d   = ST_CA;
        ccnt_d = '0;
      end
      for (int unsigned h = 0; h < 2; h++) begin
        if (phy_ck_en[h]) begin
          case (st_d)
            ST_CA: if (phy_dq_oe[h]) begin
              p_kind[h] = RSP_CA;
              if (ccnt_d == 2'd2) begin
                rd_d   = ca_d[CA_RW_BIT-CA_HI_LSB];
                reg_d  = ca_d[CA_REG_BIT-CA_HI_LSB];
                wrap_d = ~ca_d[CA_LIN_BIT-CA_HI_LSB];
                addr_d = {ca_d[CA_ADDR_HI-CA_HI_LSB:0], phy_dq_out[16*h+8 +: 3]};
                lcnt_d = LAT_PULSES;
                st_d   = (!rd_d && reg_d) ? ST_RWR : ST_LAT;
              end else begin
                ca_d   = {ca_d[15:0], phy_dq_out[16*h +: 8], phy_dq_out[16*h+8 +: 8]};
                ccnt_d = ccnt_d + 2'd1;
              end
            end
            ST_LAT: begin
              lcnt_d = lcnt_d - 8'd1;
              if (lcnt_d == 8'd0) st_d = rd_d ? ST_RDATA : ST_WDATA;
            end
            ST_RDATA: begin
              if (reg_d) begin
                p_kind[h] = RSP_REG;
                p_val[h]  = reg_read(addr_d, cr0_d, cr1_d);
              end else begin
                p_kind[h]            = RSP_RAM;
                p_bank[h]            = addr_d[0];
                bk_en[addr_d[0]]     = 1'b1;
                bk_addr[addr_d[0]]   = addr_d[AW-1:1];
              end
              addr_d = next_word_addr(addr_d, wrap_d);
            end
            ST_WDATA: if (phy_dq_oe[h]) begin
              bk_en[addr_d[0]]    = 1'b1;
              bk_we[addr_d[0]]    = 1'b1;
              bk_addr[addr_d[0]]  = addr_d[AW-1:1];
              bk_wdata[addr_d[0]] = {phy_dq_out[16*h +: 8], phy_dq_out[16*h+8 +: 8]};
              // A mask only counts while the controller actually drives RWDS.
              bk_be[addr_d[0]]    = {~(phy_rwds_out[2*h]   & phy_rwds_oe[h]),
                                     ~(phy_rwds_out[2*h+1] & phy_rwds_oe[h])};
              addr_d = next_word_addr(addr_d, wrap_d);
            end
            ST_RWR: if (phy_dq_oe[h]) begin
              if (addr_d == REG_CR0_ADDR) cr0_d = {phy_dq_out[16*h +: 8], phy_dq_out[16*h+8 +: 8]};
              if (addr_d == REG_CR1_ADDR) cr1_d = {phy_dq_out[16*h +: 8], phy_dq_out[16*h+8 +: 8]};
              st_d = ST_DONE;
            end
            default: ;
          endcase
        end
      end
    end
  end

  for (genvar g = 0; g < 2; g++) begin : g_bank
    hbus_tgt_bank #(.AW(AW)) u_bank (
      .clk   (clk),
      .en    (bk_en[g]),
      .we    (bk_we[g]),
      .be    (bk_be[g]),
      .addr  (bk_addr[g]),
      .wdata (bk_wdata[g]),
      .rdata (bk_rdata[g])
    );
  end

  // Second pipeline stage: bank data arrives here one clock after the access.
  always_comb begin
    dq_d   = '0;
    rwds_d = '0;
    for (int unsigned h = 0; h < 2; h++) begin
      case (s1_kind[h])
        RSP_CA:  rwds_d[2*h +: 2] = 2'b11;
        RSP_RAM: begin
          dq_d[16*h +: 16] = {bk_rdata[s1_bank[h]][7:0], bk_rdata[s1_bank[h]][15:8]};
          rwds_d[2*h +: 2] = 2'b01;
        end
        RSP_REG: begin
          dq_d[16*h +: 16] = {s1_val[h][7:0], s1_val[h][15:8]};
          rwds_d[2*h +: 2] = 2'b01;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      st_q   <= ST_IDLE;  ca_q   <= '0; ccnt_q <= '0; lcnt_q <= '0;
      addr_q <= '0;       rd_q   <= 1'b0; reg_q <= 1'b0; wrap_q <= 1'b0;
      cr0_q  <= CR0_RST;  cr1_q  <= CR1_RST;
      s1_kind[0] <= RSP_NONE; s1_kind[1] <= RSP_NONE;
      s1_bank    <= '0;
      s1_val[0]  <= '0; s1_val[1] <= '0;
      dq_q   <= '0;       rwds_q <= '0;
    end else begin
      st_q   <= st_d;     ca_q   <= ca_d; ccnt_q <= ccnt_d; lcnt_q <= lcnt_d;
      addr_q <= addr_d;   rd_q   <= rd_d; reg_q <= reg_d;   wrap_q <= wrap_d;
      cr0_q  <= cr0_d;    cr1_q  <= cr1_d;
      s1_kind[0] <= p_kind[0]; s1_kind[1] <= p_kind[1];
      s1_bank    <= p_bank;
      s1_val[0]  <= p_val[0];  s1_val[1] <= p_val[1];
      dq_q   <= dq_d;     rwds_q <= rwds_d;
    end
  end

  assign phy_dq_in   = dq_q;
  assign phy_rwds_in = rwds_q;
  assign cfg_cr0     = cr0_q;
  assign busy        = (st_q != ST_IDLE);

endmodule
